serial_adder_seq: RTL and testbench

Bit-serial multi-bit adder sequencer built around a single one-bit full adder cell. Each cycle it feeds that cell one operand bit pair plus a registered carry, then captures the cell's sum and carry-out. It is the control and storage stage directly around the combinational adder cell, and turns it into a WIDTH-bit adder with a start/done handshake. It trades latency (WIDTH+1 cycles) for area.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_adder_seq_fa.sv | 13 +
 rtl/serial_adder_seq.sv | 98 +++++++++
 tb/tb_serial_adder_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: sequencer states and default width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_seq_fa.sv
// One-bit full adder cell; the only arithmetic in the serial adder datapath.
module serial_adder_seq_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// WIDTH-bit adder built by feeding one full adder cell one bit pair per cycle, LSB first.
// Handshake: start is sampled only in IDLE; done pulses for one cycle; busy covers RUN and DONE.
module serial_adder_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] psum_next;

    serial_adder_seq_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Partial sum after this edge's bit lands in the MSB; complete on the last bit.
    assign psum_next = {cell_s, psum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= psum_next;
                    carry <= cell_co;
                    if (cnt == LAST) begin
                        // Counter parks at zero instead of overflowing its width.
                        cnt   <= '0;
                        sum   <= psum_next;
                        cout  <= cell_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: WIDTH=8 directed/random/corner sequences and WIDTH=4 exhaustive.
module tb_serial_adder_seq;
    import serial_add_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT WIDTH=8 ----------------
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    state_t     state8;

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state(state8)
    );

    // ---------------- DUT WIDTH=4 ----------------
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;
    state_t     state4;

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state(state4)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned addition widened by one bit.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 5'(c);
    endfunction

    // ---------------- driver tasks ----------------
    // One WIDTH=8 operation from IDLE. noisy=1 keeps start high with changing operands
    // through RUN and the DONE->IDLE edge to show they are ignored.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [8:0] expv, input string name, input bit noisy);
        int n;
        int dones;
        @(negedge clk);
        a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
        @(posedge clk);
        #1;
        if (!noisy) start8 = 1'b0;
        n = 0;
        dones = 0;
        while (dones == 0 && n < 20) begin
            if (noisy) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done8) dones++;
        end
        check({name, "_latency"}, 32'(n), 32'd8);
        check({name, "_sum"}, 32'(sum8), 32'(expv[7:0]));
        check({name, "_cout"}, 32'(cout8), 32'(expv[8]));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check({name, "_done_pulses"}, 32'(dones), 32'd1);
        check({name, "_idle_busy"}, 32'(busy8), 32'd0);
        last_res = expv;
    endtask

    task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        int n;
        @(negedge clk);
        a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 12) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check($sformatf("exh4_%0h_%0h_%0d", va, vb, vc),
              32'({n[3:0], cout4, sum4}), 32'({4'd4, model4(va, vb, vc)}));
        @(posedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ops;
        int cyc;
        int last_done;
        int hold_err;
        int n;
        logic [8:0] res;
        logic [7:0] ra, rb;
        logic rc;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'({cout8, sum8}), 32'd0);
        check("rst_state", 32'(state8), 32'(IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].ecout, vecs[i].esum},
                 $sformatf("vec%0d", i), 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
            run8(ra, rb, rc, model8(ra, rb, rc), $sformatf("rand%0d", i), 1'b0);
        end

        // start re-pulsed in RUN and DONE with other operands
        run8(8'h5A, 8'h33, 1'b0, 9'h08D, "ignore_start", 1'b1);

        // reset during cycle 4 of RUN
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrun_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_busy", 32'(busy8), 32'd0);
        check("midrun_rst_done", 32'(done8), 32'd0);
        check("midrun_rst_result", 32'({cout8, sum8}), 32'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) n++;
        end
        check("midrun_no_done", 32'(n), 32'd0);
        check("midrun_result_held", 32'({cout8, sum8}), 32'd0);
        last_res = '0;
        run8(8'hC3, 8'h7E, 1'b1, model8(8'hC3, 8'h7E, 1'b1), "after_rst", 1'b0);

        // start held high continuously: one accept per WIDTH+2 cycles
        exp_q.delete();
        ops = 0; cyc = 0; last_done = -1; hold_err = 0;
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
        a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
        exp_q.push_back(model8(ra, rb, rc));
        while (ops < 4 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done8) begin
                res = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                check($sformatf("b2b%0d_result", ops), 32'({cout8, sum8}), 32'(res));
                if (last_done < 0) check("b2b_first_latency", 32'(cyc), 32'd9);
                else check($sformatf("b2b%0d_gap", ops), 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                last_res = res;
                ops++;
                if (ops < 4) begin
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
                    a8 = ra; b8 = rb; cin8 = rc;
                    exp_q.push_back(model8(ra, rb, rc));
                end else begin
                    start8 = 1'b0;
                end
            end else if ({cout8, sum8} !== last_res) begin
                hold_err++;
            end
        end
        start8 = 1'b0;
        check("b2b_ops_completed", 32'(ops), 32'd4);
        check("b2b_sum_hold", 32'(hold_err), 32'd0);
        repeat (3) @(posedge clk);

        // WIDTH=4 exhaustive
        for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run4(4'(x), 4'(y), 1'(c));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
